// File: rtl/spi_pixel_slave_rx_tx.sv
// spi_pixel_slave_rx_tx
// ---------------------------------------------------------------------------
// Fully synchronous SPI slave for the dither accelerator. SPI_CLK, SPI_CS and
// SPI_MOSI are oversampled in the clk domain. Words of WORD_WIDTH bits are
// assembled in any of the four SPI modes and queued in an RX FIFO. Result
// words are shifted out on SPI_MISO. Accepted words are counted per image
// frame, and request_flag pulses at each frame boundary.
//
// Ports
//   clk, rst             system clock, synchronous active-high reset
//   SPI_CLK/CS/MOSI      SPI master inputs (asynchronous to clk)
//   SPI_MISO, miso_oe    slave data out and its tri-state enable
//   rx_data/valid/ready  RX FIFO head, with pop on rx_valid && rx_ready
//   tx_data/valid/ready  next TX word, with tx_ready strobing on each load
//   request_flag         one-cycle pulse when a frame of IMAGE_SIZE words completes
//   word_count           words accepted in the current frame
//   overflow             sticky flag: a word was dropped on a full FIFO
//   busy                 synchronised chip select is active
// ---------------------------------------------------------------------------
module spi_pixel_slave_rx_tx #(
  parameter int WORD_WIDTH  = 8,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int MSB_FIRST   = 1,
  parameter int FIFO_DEPTH  = 16,
  parameter int IMAGE_SIZE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              SPI_CLK,
  input  logic                              SPI_CS,
  input  logic                              SPI_MOSI,
  output logic                              SPI_MISO,
  output logic                              miso_oe,
  output logic [WORD_WIDTH-1:0]             rx_data,
  output logic                              rx_valid,
  input  logic                              rx_ready,
  input  logic [WORD_WIDTH-1:0]             tx_data,
  input  logic                              tx_valid,
  output logic                              tx_ready,
  output logic                              request_flag,
  output logic [$clog2(IMAGE_SIZE+1)-1:0]   word_count,
  output logic                              overflow,
  output logic                              busy
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(IMAGE_SIZE+1);
  localparam int BCW = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
  localparam logic [BCW-1:0] LAST     = BCW'(WORD_WIDTH-1);
  localparam logic [CW-1:0]  FRM_LAST = CW'(IMAGE_SIZE-1);
  localparam logic IDLE_CLK    = (CPOL != 0);
  // Leading edge is rising when CPOL=0; CPHA=0 samples on the leading edge.
  localparam logic SAMPLE_RISE = (CPOL == CPHA);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, COMMIT} state_t;

  // ---------------------------------------------------------------------
  // Input synchronisers and edge detection
  // ---------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] clk_sync, cs_sync, mosi_sync;
  logic                   sclk_d, cs_d;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   rise, fall, samp_edge, shft_edge, cs_fall, cs_rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync  <= {SYNC_STAGES{IDLE_CLK}};
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= IDLE_CLK;
      cs_d      <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], SPI_CLK};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], SPI_CS};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], SPI_MOSI};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
    end
  end

  assign sclk_s = clk_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign busy    = ~cs_s;
  assign miso_oe = busy;
  assign rise    = sclk_s & ~sclk_d;
  assign fall    = ~sclk_s & sclk_d;
  assign cs_fall = ~cs_s & cs_d;
  assign cs_rise = cs_s & ~cs_d;

  // Clock edges while deselected are ignored.
  assign samp_edge = busy & (SAMPLE_RISE ? rise : fall);
  assign shft_edge = busy & (SAMPLE_RISE ? fall : rise);

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------
  state_t         state, state_nx;
  logic [BCW-1:0] bit_cnt;
  logic           load_tx, push;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    load_tx  = 1'b0;
    push     = 1'b0;
    case (state)
      IDLE:   if (cs_fall) state_nx = LOAD;
      LOAD: begin
        load_tx  = 1'b1;
        state_nx = SHIFT;
      end
      SHIFT:  if (samp_edge && bit_cnt == LAST) state_nx = COMMIT;
      COMMIT: begin
        // The word is complete, so it is pushed even if CS is rising now.
        push     = 1'b1;
        load_tx  = 1'b1;
        state_nx = busy ? SHIFT : IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (cs_rise) state_nx = IDLE;
  end

  assign tx_ready = load_tx & tx_valid;

  // ---------------------------------------------------------------------
  // Shift datapath
  // ---------------------------------------------------------------------
  logic [WORD_WIDTH-1:0] rx_sr, tx_word, tx_nx;
  logic [BCW-1:0]        tx_idx;
  logic                  tx_first, miso_q;

  assign tx_nx    = tx_valid ? tx_data : '0;
  assign tx_first = (MSB_FIRST != 0) ? tx_nx[WORD_WIDTH-1] : tx_nx[0];
  // The bit driven on a shift edge is the one the next sample will pick up,
  // which is always position bit_cnt in transmit order.
  assign tx_idx   = (MSB_FIRST != 0) ? (LAST - bit_cnt) : bit_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt <= '0;
      rx_sr   <= '0;
      tx_word <= '0;
      miso_q  <= 1'b0;
    end else if (cs_rise) begin
      // Any partial word is dropped here.
      bit_cnt <= '0;
      miso_q  <= 1'b0;
    end else begin
      if (load_tx) begin
        tx_word <= tx_nx;
        // CPHA=0 must present the first bit before the first clock edge.
        if (CPHA == 0) miso_q <= tx_first;
      end
      if (state == LOAD) bit_cnt <= '0;
      if (state == SHIFT && samp_edge) begin
        if (MSB_FIRST != 0) rx_sr <= {rx_sr[WORD_WIDTH-2:0], mosi_s};
        else                rx_sr <= {mosi_s, rx_sr[WORD_WIDTH-1:1]};
        bit_cnt <= (bit_cnt == LAST) ? '0 : bit_cnt + 1'b1;
      end
      // With CPHA=0 the trailing edge after the last sample belongs to the
      // finished word; bit_cnt is already 0, so it must not advance MISO.
      if (state == SHIFT && shft_edge && (CPHA != 0 || bit_cnt != '0))
        miso_q <= tx_word[tx_idx];
    end
  end

  assign SPI_MISO = miso_oe & miso_q;

  // ---------------------------------------------------------------------
  // RX FIFO: extra pointer MSB distinguishes full from empty
  // ---------------------------------------------------------------------
  logic [WORD_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0]           wr_ptr, rd_ptr;
  logic                  empty, full, pop, push_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rx_valid = ~empty;
  assign pop     = rx_valid & rx_ready;
  // A pop in the same cycle frees the slot being written.
  assign push_ok = push & (~full | pop);
  assign rx_data = rx_valid ? mem[rd_ptr[AW-1:0]] : '0;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= rx_sr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      overflow     <= 1'b0;
      word_count   <= '0;
      request_flag <= 1'b0;
    end else begin
      request_flag <= 1'b0;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push && full && !pop) overflow <= 1'b1;
      if (push_ok) begin
        if (word_count == FRM_LAST) begin
          word_count   <= '0;
          request_flag <= 1'b1;
        end else begin
          word_count <= word_count + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_pixel_slave_rx_tx.sv
module tb_spi_pixel_slave_rx_tx;
  localparam int HP = 6;  // clk cycles per SPI_CLK level

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, sel, sclk, cs, mosi, force_pop;
  logic [7:0] tx_data;
  logic       tx_valid, rx_rdy_a, rx_rdy_b;

  logic       sclk_a, cs_a, sclk_b, cs_b, rx_ready_a, rx_ready_b;
  logic       miso_a, oe_a, rxv_a, txr_a, req_a, ovf_a, busy_a;
  logic       miso_b, oe_b, rxv_b, txr_b, req_b, ovf_b, busy_b;
  logic [7:0] rxd_a, rxd_b;
  logic [4:0] wc_a, wc_b;

  // sel routes the one bench master to DUT A (mode 0) or DUT B (mode 3).
  assign sclk_a = sel ? 1'b0 : sclk;
  assign cs_a   = sel ? 1'b1 : cs;
  assign sclk_b = sel ? sclk : 1'b1;
  assign cs_b   = sel ? cs : 1'b1;
  // force_pop pops exactly in the COMMIT cycle, marked by tx_ready.
  assign rx_ready_a = force_pop ? txr_a : rx_rdy_a;
  assign rx_ready_b = rx_rdy_b;

  spi_pixel_slave_rx_tx #(.WORD_WIDTH(8), .CPOL(0), .CPHA(0), .MSB_FIRST(1),
    .FIFO_DEPTH(4), .IMAGE_SIZE(16), .SYNC_STAGES(2)) dut_a (
    .clk(clk), .rst(rst), .SPI_CLK(sclk_a), .SPI_CS(cs_a), .SPI_MOSI(mosi),
    .SPI_MISO(miso_a), .miso_oe(oe_a), .rx_data(rxd_a), .rx_valid(rxv_a),
    .rx_ready(rx_ready_a), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(txr_a),
    .request_flag(req_a), .word_count(wc_a), .overflow(ovf_a), .busy(busy_a));

  spi_pixel_slave_rx_tx #(.WORD_WIDTH(8), .CPOL(1), .CPHA(1), .MSB_FIRST(0),
    .FIFO_DEPTH(16), .IMAGE_SIZE(16), .SYNC_STAGES(2)) dut_b (
    .clk(clk), .rst(rst), .SPI_CLK(sclk_b), .SPI_CS(cs_b), .SPI_MOSI(mosi),
    .SPI_MISO(miso_b), .miso_oe(oe_b), .rx_data(rxd_b), .rx_valid(rxv_b),
    .rx_ready(rx_ready_b), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(txr_b),
    .request_flag(req_b), .word_count(wc_b), .overflow(ovf_b), .busy(busy_b));

  // Monitor: popped words, tx_ready and request_flag high cycles.
  logic [7:0] q_a[$], q_b[$];
  int txr_cnt_a = 0, txr_cnt_b = 0, req_cnt_a = 0, req_cnt_b = 0;
  always @(negedge clk) begin
    #2;
    if (rxv_a && rx_ready_a) q_a.push_back(rxd_a);
    if (rxv_b && rx_ready_b) q_b.push_back(rxd_b);
    if (txr_a) txr_cnt_a++;
    if (txr_b) txr_cnt_b++;
    if (req_a) req_cnt_a++;
    if (req_b) req_cnt_b++;
  end

  int checks = 0, errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_sel(input logic s);
    sclk = s;  // idle level: CPOL of the selected DUT
    sel  = s;
    cs   = 1'b1;
    wait_clk(4);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wait_clk(2);
    rst = 1'b0;
    wait_clk(2);
  endtask

  // Sends wb[7] first on the wire; cap collects MISO at each sample edge,
  // first sampled bit into cap[7].
  task automatic spi_xfer(input logic [7:0] wb, input int nbits, output logic [7:0] cap);
    cap = 8'h00;
    cs  = 1'b0;
    wait_clk(8);
    for (int i = 0; i < nbits; i++) begin
      if (!sel) begin
        mosi = wb[7-i];
        wait_clk(HP);
        sclk = 1'b1;
        cap[7-i] = miso_a;
        wait_clk(HP);
        sclk = 1'b0;
      end else begin
        sclk = 1'b0;
        mosi = wb[7-i];
        wait_clk(HP);
        sclk = 1'b1;
        cap[7-i] = miso_b;
        wait_clk(HP);
      end
    end
    wait_clk(HP);
    cs = 1'b1;
    wait_clk(8);
  endtask

  typedef struct {
    logic       s;
    logic [7:0] wb;
    logic [7:0] txd;
    logic       txv;
    logic [7:0] exp_rx;
    logic [7:0] exp_miso;
  } vec_t;

  vec_t vt[6];
  logic [7:0] cap;
  int qb, tb0;

  initial begin
    vt[0] = '{1'b0, 8'h3C, 8'h5A, 1'b1, 8'h3C, 8'h5A};
    vt[1] = '{1'b0, 8'h81, 8'hFF, 1'b0, 8'h81, 8'h00};
    vt[2] = '{1'b0, 8'hFE, 8'hC3, 1'b1, 8'hFE, 8'hC3};
    vt[3] = '{1'b1, 8'b00110111, 8'hA5, 1'b1, 8'hEC, 8'b10100101};
    vt[4] = '{1'b1, 8'h80, 8'h0F, 1'b1, 8'h01, 8'hF0};
    vt[5] = '{1'b1, 8'hC1, 8'h77, 1'b0, 8'h83, 8'h00};

    sel = 1'b0; sclk = 1'b0; cs = 1'b1; mosi = 1'b0; force_pop = 1'b0;
    tx_data = 8'h00; tx_valid = 1'b0; rx_rdy_a = 1'b0; rx_rdy_b = 1'b0;
    rst = 1'b1;
    wait_clk(4);

    // Reset state
    check("rst_miso", miso_a, 0);
    check("rst_oe", oe_a, 0);
    check("rst_rxv", rxv_a, 0);
    check("rst_rxd", rxd_a, 0);
    check("rst_txr", txr_a, 0);
    check("rst_req", req_a, 0);
    check("rst_wc", wc_a, 0);
    check("rst_ovf", ovf_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_b_state", {rxv_b, oe_b, busy_b, ovf_b, wc_b}, 0);
    rst = 1'b0;
    wait_clk(2);

    // Table: one CS-framed word per entry, immediate pop
    rx_rdy_a = 1'b1; rx_rdy_b = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_sel(vt[i].s);
      tx_data = vt[i].txd; tx_valid = vt[i].txv;
      qb  = sel ? q_b.size() : q_a.size();
      tb0 = sel ? txr_cnt_b : txr_cnt_a;
      spi_xfer(vt[i].wb, 8, cap);
      wait_clk(4);
      if (sel) begin
        check($sformatf("vec%0d_rx_cnt", i), q_b.size() - qb, 1);
        if (q_b.size() > qb) check($sformatf("vec%0d_rx", i), q_b[qb], vt[i].exp_rx);
        // LOAD plus the reload in COMMIT
        check($sformatf("vec%0d_txr", i), txr_cnt_b - tb0, vt[i].txv ? 2 : 0);
      end else begin
        check($sformatf("vec%0d_rx_cnt", i), q_a.size() - qb, 1);
        if (q_a.size() > qb) check($sformatf("vec%0d_rx", i), q_a[qb], vt[i].exp_rx);
        check($sformatf("vec%0d_txr", i), txr_cnt_a - tb0, vt[i].txv ? 2 : 0);
      end
      check($sformatf("vec%0d_miso", i), cap, vt[i].exp_miso);
    end
    tx_valid = 1'b0;
    set_sel(1'b0);

    // Frame: 16 words of FE, one request pulse after the 16th
    do_reset();
    rx_rdy_a = 1'b1;
    qb  = q_a.size();
    tb0 = req_cnt_a;
    for (int i = 0; i < 15; i++) spi_xfer(8'hFE, 8, cap);
    check("frame_wc15", wc_a, 15);
    check("frame_req_early", req_cnt_a - tb0, 0);
    spi_xfer(8'hFE, 8, cap);
    wait_clk(4);
    check("frame_req", req_cnt_a - tb0, 1);
    check("frame_wc0", wc_a, 0);
    check("frame_pops", q_a.size() - qb, 16);
    begin
      int nfe = 0;
      for (int k = qb; k < q_a.size(); k++) if (q_a[k] == 8'hFE) nfe++;
      check("frame_data", nfe, 16);
    end

    // Overflow: depth-4 FIFO, no pops, 6 words
    do_reset();
    rx_rdy_a = 1'b0;
    for (int v = 1; v <= 6; v++) spi_xfer(8'(v), 8, cap);
    check("ovf_rxv", rxv_a, 1);
    check("ovf_flag", ovf_a, 1);
    check("ovf_wc", wc_a, 4);
    qb = q_a.size();
    rx_rdy_a = 1'b1;
    wait_clk(8);
    check("ovf_drain_cnt", q_a.size() - qb, 4);
    for (int k = 0; k < 4; k++)
      if (q_a.size() > qb + k) check($sformatf("ovf_drain%0d", k), q_a[qb+k], k + 1);
    check("ovf_empty", rxv_a, 0);
    check("ovf_sticky", ovf_a, 1);

    // Partial word: CS rises after 5 bits
    do_reset();
    rx_rdy_a = 1'b1;
    qb = q_a.size();
    spi_xfer(8'hA7, 5, cap);
    check("part_wc", wc_a, 0);
    check("part_nopush", q_a.size() - qb, 0);
    spi_xfer(8'h3C, 8, cap);
    check("part_next_cnt", q_a.size() - qb, 1);
    if (q_a.size() > qb) check("part_next", q_a[qb], 8'h3C);
    check("part_next_wc", wc_a, 1);

    // Full FIFO with pop and push in the same cycle
    do_reset();
    rx_rdy_a = 1'b0;
    for (int v = 0; v < 4; v++) spi_xfer(8'h10 + 8'(v), 8, cap);
    tx_valid = 1'b1;
    qb = q_a.size();
    fork
      spi_xfer(8'h14, 8, cap);
      begin wait_clk(30); force_pop = 1'b1; end
    join
    force_pop = 1'b0;
    tx_valid  = 1'b0;
    check("simul_ovf", ovf_a, 0);
    check("simul_wc", wc_a, 5);
    check("simul_pop_cnt", q_a.size() - qb, 1);
    rx_rdy_a = 1'b1;
    wait_clk(8);
    check("simul_total", q_a.size() - qb, 5);
    for (int k = 0; k < 5; k++)
      if (q_a.size() > qb + k) check($sformatf("simul_order%0d", k), q_a[qb+k], 8'h10 + k);

    // Reset mid-word with three words queued
    do_reset();
    rx_rdy_a = 1'b0;
    for (int v = 0; v < 3; v++) spi_xfer(8'h21 + 8'(v), 8, cap);
    check("mid_wc3", wc_a, 3);
    fork
      spi_xfer(8'h99, 8, cap);
      begin
        wait_clk(50);
        rst = 1'b1;
        wait_clk(1);
        check("mid_rxv", rxv_a, 0);
        check("mid_wc", wc_a, 0);
        check("mid_oe", oe_a, 0);
        rst = 1'b0;
      end
    join
    check("mid_nopush", rxv_a, 0);
    rx_rdy_a = 1'b1;
    qb = q_a.size();
    spi_xfer(8'h5A, 8, cap);
    check("mid_after_cnt", q_a.size() - qb, 1);
    if (q_a.size() > qb) check("mid_after", q_a[qb], 8'h5A);
    check("mid_after_wc", wc_a, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_pixel_slave_rx_tx.md
Name: spi_pixel_slave_rx_tx

Overview:
Parametrised, fully synchronous SPI slave for the dither accelerator, replacing the fixed 8-bit, mode-0 receive-only pixel path.
- Oversamples SPI_CLK, SPI_CS and SPI_MOSI in the system clock domain.
- Assembles WORD_WIDTH-bit words in any of the four SPI modes and buffers them in an RX FIFO for the dither core.
- Shifts result words out on SPI_MISO.
- Counts words per image frame and pulses request_flag at each frame boundary.

Parameters:
- WORD_WIDTH, 8: bits per SPI word (pixel or RGB channel).
- CPOL, 0: SPI clock idle level.
- CPHA, 0: 0 = sample on leading edge; 1 = sample on trailing edge.
- MSB_FIRST, 1: bit order for both RX and TX.
- FIFO_DEPTH, 16: RX FIFO entries; must be a power of two, ≥2.
- IMAGE_SIZE, 16: words per frame.
- SYNC_STAGES, 2: synchroniser flops on SPI inputs; must be ≥2.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: synchronous, active-high reset.
- SPI_CLK, in, 1: SPI clock from master.
- SPI_CS, in, 1: chip select, active low.
- SPI_MOSI, in, 1: master-out data.
- SPI_MISO, out, 1: slave-out data.
- miso_oe, out, 1: MISO output enable (tri-state control at top level).
- rx_data, out, WORD_WIDTH: FIFO head word.
- rx_valid, out, 1: FIFO non-empty.
- rx_ready, in, 1: consumer pops head when rx_valid && rx_ready.
- tx_data, in, WORD_WIDTH: next word to transmit.
- tx_valid, in, 1: tx_data available.
- tx_ready, out, 1: one-cycle strobe; tx_data loaded this cycle.
- request_flag, out, 1: one-cycle pulse at frame completion.
- word_count, out, $clog2(IMAGE_SIZE+1): accepted words in current frame.
- overflow, out, 1: sticky; a word was dropped because the FIFO was full.
- busy, out, 1: SPI_CS (synchronised) low.

Behaviour:
- Reset state: SPI_MISO=0, miso_oe=0, rx_valid=0, rx_data=0, tx_ready=0, request_flag=0, word_count=0, overflow=0, busy=0. FIFO empty, shift counters cleared, FSM in IDLE.
- Reset asserted mid-word discards the partial word and all FIFO contents.
- Input timing: inputs pass through SYNC_STAGES flops. Edge detect compares the last two synchronised SPI_CLK samples. Requirement: each SPI_CLK level lasts ≥2 clk cycles (SPI_CLK ≤ clk/4).
- Edge selection:
  - Sample edge is rising when CPOL==CPHA, falling otherwise; the shift edge is the opposite edge.
  - SPI_CLK edges while CS is high are ignored.
- FSM:
  - IDLE → LOAD on synchronised CS falling.
  - LOAD (1 cycle): if tx_valid, latch tx_data into the TX shift register and pulse tx_ready; else load all zeros. Drive the first bit on MISO (CPHA=0). Go to SHIFT.
  - SHIFT: on each sample edge, shift MOSI into the RX register (MSB_FIRST selects direction) and increment bit_cnt.
    - On the WORD_WIDTH-th sample, go to COMMIT.
    - On each shift edge, advance the MISO bit.
    - For CPHA=1, the first shift edge drives bit 0 of the sequence.
  - COMMIT (1 cycle): push the word to the FIFO; bit_cnt=0; reload TX as in LOAD. Return to SHIFT if CS is low, else IDLE.
  - Any state: synchronised CS rising → IDLE. A partial word is discarded (no push, no count). miso_oe=0.
- miso_oe equals busy. SPI_MISO holds its last bit between edges and is 0 when miso_oe=0.
- FIFO:
  - Push in COMMIT; pop on rx_valid && rx_ready.
  - Full with no pop: word dropped, overflow←1 until rst, word_count unchanged.
  - Full with simultaneous pop: push accepted, occupancy unchanged.
  - Empty with simultaneous push: rx_valid rises the next cycle; no pop occurs.
  - rx_data is the registered head; it is stable while rx_valid && !rx_ready.
- Latency: sampling edge of the last bit at the pin → rx_valid high in ≤ SYNC_STAGES+3 clk cycles.
- Frame counting:
  - word_count increments per accepted push.
  - When an accepted push makes the count reach IMAGE_SIZE, word_count wraps to 0 in the same cycle and request_flag pulses high for exactly one cycle.
  - Dropped words do not count.
- Pointer arithmetic: read and write pointers are $clog2(FIFO_DEPTH)+1 bits wide and wrap modulo 2×FIFO_DEPTH. Full and empty are decoded from the MSB difference.

Test Plan:
- Mode 0, WORD_WIDTH=8: 16 CS-framed bytes 8'hFE with rx_ready=1 → 16 pops of 8'hFE; request_flag pulses exactly once, after the 16th push; word_count returns to 0.
- Mode 3 (CPOL=1, CPHA=1), MSB_FIRST=0: send 8'b00110111 LSB-first → rx_data=8'hEC. With tx_data=8'hA5 and tx_valid=1, MISO shows 1,0,1,0,0,1,0,1 on successive sample edges.
- Overflow: FIFO_DEPTH=4, rx_ready=0, send 6 words 1..6 → rx_valid=1, overflow=1, word_count=4; draining yields 1,2,3,4.
- CS raised after 5 bits of a word → no push, word_count unchanged. The next complete word 8'h3C is received intact.
- Full FIFO, pop and push in the same cycle → occupancy stays at FIFO_DEPTH, overflow stays 0, order preserved.
- rst asserted during SHIFT with 3 words queued → next cycle rx_valid=0, word_count=0, miso_oe=0. A subsequent frame works normally.
